// File: rtl/efb_wb_arbiter.sv
// Two-requester Wishbone arbiter for the EFB slave port.
// Round-robin grant, one-cycle idle gap, ack timeout.
module efb_wb_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Req0,
  input  logic       i_Req1,
  input  logic       i_We0,
  input  logic       i_We1,
  input  logic [7:0] i_Addr0,
  input  logic [7:0] i_Addr1,
  input  logic [7:0] i_WData0,
  input  logic [7:0] i_WData1,
  output logic       o_Done0,
  output logic       o_Done1,
  output logic [7:0] o_RData,
  output logic       o_Error,
  output logic       o_Busy,
  output logic       o_wb_cyc,
  output logic       o_wb_stb,
  output logic       o_wb_we,
  output logic [7:0] o_wb_adr,
  output logic [7:0] o_wb_dat,
  input  logic [7:0] i_wb_dat,
  input  logic       i_wb_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GAP
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic       last;
  logic       last_nx;
  logic       gnt;
  logic       gnt_nx;
  logic       pick1;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       done0_nx;
  logic       done1_nx;
  logic       err_nx;
  logic       busy_nx;
  logic       cyc_nx;
  logic       we_nx;
  logic [7:0] adr_nx;
  logic [7:0] dat_nx;
  logic [7:0] rdata_nx;

  // last == 1 means requester 1 was served most recently
  assign pick1 = i_Req1 & (~i_Req0 | ~last);

  always_comb begin
    state_nx = state;
    last_nx  = last;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
    err_nx   = 1'b0;
    cyc_nx   = o_wb_cyc;
    we_nx    = o_wb_we;
    adr_nx   = o_wb_adr;
    dat_nx   = o_wb_dat;
    rdata_nx = o_RData;

    unique case (state)
      IDLE: begin
        if (i_Req0 | i_Req1) begin
          gnt_nx   = pick1;
          last_nx  = pick1;
          we_nx    = pick1 ? i_We1 : i_We0;
          adr_nx   = pick1 ? i_Addr1 : i_Addr0;
          dat_nx   = pick1 ? i_WData1 : i_WData0;
          cyc_nx   = 1'b1;
          cnt_nx   = 8'd0;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (i_wb_ack) begin
          cyc_nx   = 1'b0;
          if (!o_wb_we) begin
            rdata_nx = i_wb_dat;
          end
          done0_nx = ~gnt;
          done1_nx = gnt;
          state_nx = GAP;
        end else if (cnt == CNT_MAX) begin
          cyc_nx   = 1'b0;
          rdata_nx = 8'h00;
          done0_nx = ~gnt;
          done1_nx = gnt;
          err_nx   = 1'b1;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= 8'd0;
      o_Done0  <= 1'b0;
      o_Done1  <= 1'b0;
      o_Error  <= 1'b0;
      o_Busy   <= 1'b0;
      o_RData  <= 8'h00;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we  <= 1'b0;
      o_wb_adr <= 8'h00;
      o_wb_dat <= 8'h00;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      gnt      <= gnt_nx;
      cnt      <= cnt_nx;
      o_Done0  <= done0_nx;
      o_Done1  <= done1_nx;
      o_Error  <= err_nx;
      o_Busy   <= busy_nx;
      o_RData  <= rdata_nx;
      o_wb_cyc <= cyc_nx;
      o_wb_stb <= cyc_nx;
      o_wb_we  <= we_nx;
      o_wb_adr <= adr_nx;
      o_wb_dat <= dat_nx;
    end
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Randomized scoreboard bench for efb_wb_arbiter.
// Slave model, requesters and monitor run as separate processes.
module tb_efb_wb_arbiter;
  localparam int TO = 4;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Req0 = 1'b0;
  logic       i_Req1 = 1'b0;
  logic       i_We0 = 1'b0;
  logic       i_We1 = 1'b0;
  logic [7:0] i_Addr0 = 8'h00;
  logic [7:0] i_Addr1 = 8'h00;
  logic [7:0] i_WData0 = 8'h00;
  logic [7:0] i_WData1 = 8'h00;
  logic       o_Done0;
  logic       o_Done1;
  logic [7:0] o_RData;
  logic       o_Error;
  logic       o_Busy;
  logic       o_wb_cyc;
  logic       o_wb_stb;
  logic       o_wb_we;
  logic [7:0] o_wb_adr;
  logic [7:0] o_wb_dat;
  logic [7:0] i_wb_dat = 8'h00;
  logic       i_wb_ack = 1'b0;

  always #5 i_Clock = ~i_Clock;

  efb_wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Req0  (i_Req0),
    .i_Req1  (i_Req1),
    .i_We0   (i_We0),
    .i_We1   (i_We1),
    .i_Addr0 (i_Addr0),
    .i_Addr1 (i_Addr1),
    .i_WData0(i_WData0),
    .i_WData1(i_WData1),
    .o_Done0 (o_Done0),
    .o_Done1 (o_Done1),
    .o_RData (o_RData),
    .o_Error (o_Error),
    .o_Busy  (o_Busy),
    .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb),
    .o_wb_we (o_wb_we),
    .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat),
    .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack)
  );

  typedef struct {
    int         port;
    bit         we;
    logic [7:0] adr;
    logic [7:0] wd;
    logic [7:0] sd;
    int         delay;
    bit         spur;
    logic [7:0] rd;
    bit         err;
  } txn_t;

  txn_t busq[$];
  txn_t doneq[$];
  txn_t slq[$];

  int         checks = 0;
  int         errors = 0;
  bit         last_g = 1'b1;
  logic [7:0] m_rd = 8'h00;
  bit         aborting = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t rnd_txn(input int p);
    txn_t t;
    t.port  = p;
    t.we    = 1'($urandom);
    t.adr   = 8'($urandom);
    t.wd    = 8'($urandom);
    t.sd    = 8'($urandom);
    t.delay = int'($urandom_range(0, TO + 1));
    t.spur  = ($urandom_range(0, 3) == 0);
    t.rd    = 8'h00;
    t.err   = 1'b0;
    return t;
  endfunction

  // Reference model: outcome from ack delay, rdata sticky except reads/timeouts
  task automatic push_exp(input txn_t t);
    if (t.delay < TO) begin
      t.err = 1'b0;
      if (!t.we) m_rd = t.sd;
    end else begin
      t.err = 1'b1;
      m_rd  = 8'h00;
    end
    t.rd   = m_rd;
    last_g = (t.port == 1);
    busq.push_back(t);
    doneq.push_back(t);
    slq.push_back(t);
  endtask

  task automatic drive(input txn_t t);
    if (t.port == 0) begin
      i_We0 = t.we; i_Addr0 = t.adr; i_WData0 = t.wd; i_Req0 = 1'b1;
    end else begin
      i_We1 = t.we; i_Addr1 = t.adr; i_WData1 = t.wd; i_Req1 = 1'b1;
    end
  endtask

  task automatic scramble(input int p);
    if (p == 0) begin
      i_We0 = 1'($urandom); i_Addr0 = 8'($urandom); i_WData0 = 8'($urandom);
    end else begin
      i_We1 = 1'($urandom); i_Addr1 = 8'($urandom); i_WData1 = 8'($urandom);
    end
  endtask

  // Called at a negedge with the DUT idle
  task automatic do_txn(input txn_t a, input txn_t b, input bit r0, input bit r1);
    txn_t ord[$];
    bit   p0 = r0;
    bit   p1 = r1;
    if (r0 && r1) begin
      if (last_g) begin ord.push_back(a); ord.push_back(b); end
      else begin ord.push_back(b); ord.push_back(a); end
    end else if (r0) ord.push_back(a);
    else ord.push_back(b);
    chk("rdata_held", 32'(o_RData), 32'(m_rd));
    foreach (ord[i]) push_exp(ord[i]);
    if (r0) drive(a);
    if (r1) drive(b);
    for (int k = 0; k < 100 && (p0 || p1); k++) begin
      @(negedge i_Clock);
      if (k == 0) begin
        scramble(ord[0].port);
        if (!r0) scramble(0);
        if (!r1) scramble(1);
      end
      if (o_Done0 && p0) begin p0 = 1'b0; i_Req0 = 1'b0; end
      if (o_Done1 && p1) begin p1 = 1'b0; i_Req1 = 1'b0; end
    end
    chk("done_wait", 32'({p0, p1}), 32'd0);
    i_Req0 = 1'b0;
    i_Req1 = 1'b0;
    @(negedge i_Clock);
  endtask

  task automatic hold_both(input int n);
    txn_t a = rnd_txn(0);
    txn_t b = rnd_txn(1);
    txn_t t;
    int   seen = 0;
    chk("rdata_held", 32'(o_RData), 32'(m_rd));
    for (int i = 0; i < n; i++) begin
      t       = last_g ? a : b;
      t.sd    = 8'($urandom);
      t.delay = int'($urandom_range(0, TO + 1));
      t.spur  = 1'($urandom);
      push_exp(t);
    end
    drive(a);
    drive(b);
    for (int k = 0; k < 400 && seen < n; k++) begin
      @(negedge i_Clock);
      if (o_Done0 || o_Done1) seen++;
    end
    i_Req0 = 1'b0;
    i_Req1 = 1'b0;
    chk("hold_dones", 32'(seen), 32'(n));
    @(negedge i_Clock);
  endtask

  // Slave: acks after t.delay cycles, optional ack pulses in GAP and IDLE
  txn_t s_cur;
  bit   s_act = 1'b0;
  int   s_cnt = 0;
  int   s_spur = 0;
  always @(negedge i_Clock) begin
    i_wb_ack = 1'b0;
    if (s_spur > 0) begin
      s_spur--;
      i_wb_ack = 1'b1;
      i_wb_dat = 8'($urandom);
    end
    if (o_wb_stb) begin
      if (!s_act) begin
        s_act = 1'b1;
        s_cnt = 0;
        if (slq.size() > 0) s_cur = slq.pop_front();
        else begin s_cur.delay = TO + 1; s_cur.spur = 1'b0; end
      end else begin
        s_cnt++;
      end
      if (s_cnt == s_cur.delay && s_cur.delay < TO) begin
        i_wb_ack = 1'b1;
        i_wb_dat = s_cur.sd;
        if (s_cur.spur) s_spur = 2;
      end
    end else begin
      s_act = 1'b0;
    end
  end

  // Monitor
  txn_t m_cur;
  txn_t m_done;
  int   stb_run = 0;
  always @(negedge i_Clock) begin
    if (o_wb_stb) begin
      if (stb_run == 0) begin
        chk("cycle_expected", 32'(busq.size() != 0), 32'd1);
        if (busq.size() != 0) begin
          m_cur = busq.pop_front();
          chk("bus_fields",
              32'({o_wb_cyc, o_Busy, o_wb_we, o_wb_adr, o_wb_dat}),
              32'({1'b1, 1'b1, m_cur.we, m_cur.adr, m_cur.wd}));
        end
      end
      stb_run++;
    end else if (stb_run > 0) begin
      if (aborting) aborting = 1'b0;
      else chk("stb_cycles", 32'(stb_run),
               32'(m_cur.delay < TO ? m_cur.delay + 1 : TO));
      stb_run = 0;
    end
    if (o_Done0 || o_Done1) begin
      chk("done_onehot", 32'(o_Done0 & o_Done1), 32'd0);
      chk("done_expected", 32'(doneq.size() != 0), 32'd1);
      if (doneq.size() != 0) begin
        m_done = doneq.pop_front();
        chk("done_port", 32'(o_Done1), 32'(m_done.port));
        chk("done_rdata", 32'(o_RData), 32'(m_done.rd));
        chk("done_error", 32'(o_Error), 32'(m_done.err));
        chk("done_cyc_low", 32'(o_wb_cyc), 32'd0);
      end
    end else if (o_Error) begin
      chk("error_without_done", 32'(o_Error), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t a;
    txn_t b;
    int   pat;
    repeat (3) @(negedge i_Clock);
    chk("reset_outputs",
        32'({o_Done0, o_Done1, o_RData, o_Error, o_Busy, o_wb_cyc,
             o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat}), 32'd0);
    i_Reset = 1'b0;
    @(negedge i_Clock);

    hold_both(6);

    a = rnd_txn(0); a.we = 1'b0; a.adr = 8'h66; a.sd = 8'hA5; a.delay = 1; a.spur = 1'b1;
    do_txn(a, a, 1'b1, 1'b0);
    b = rnd_txn(1); b.we = 1'b1; b.adr = 8'h5E; b.wd = 8'h3C; b.delay = 2; b.spur = 1'b1;
    do_txn(b, b, 1'b0, 1'b1);
    a = rnd_txn(0); a.we = 1'b0; a.delay = TO + 1;
    do_txn(a, a, 1'b1, 1'b0);
    a = rnd_txn(0); a.we = 1'b0; a.delay = TO - 1;
    do_txn(a, a, 1'b1, 1'b0);
    a = rnd_txn(0); a.we = 1'b1; a.delay = TO;
    b = rnd_txn(1); b.we = 1'b1; b.delay = 0; b.spur = 1'b1;
    do_txn(a, b, 1'b1, 1'b1);

    for (int r = 0; r < 40; r++) begin
      pat = int'($urandom_range(0, 2));
      do_txn(rnd_txn(0), rnd_txn(1), pat != 1, pat != 0);
    end

    // Reset while the strobe is outstanding
    a = rnd_txn(0); a.delay = TO + 1; a.spur = 1'b0;
    chk("rdata_held", 32'(o_RData), 32'(m_rd));
    busq.push_back(a);
    slq.push_back(a);
    drive(a);
    @(negedge i_Clock);
    @(negedge i_Clock);
    aborting = 1'b1;
    i_Reset  = 1'b1;
    @(negedge i_Clock);
    chk("reset_mid_access",
        32'({o_Done0, o_Done1, o_RData, o_Error, o_Busy, o_wb_cyc,
             o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat}), 32'd0);
    i_Reset = 1'b0;
    i_Req0  = 1'b0;
    last_g  = 1'b1;
    m_rd    = 8'h00;
    @(negedge i_Clock);
    do_txn(rnd_txn(0), rnd_txn(1), 1'b1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      pat = int'($urandom_range(0, 2));
      do_txn(rnd_txn(0), rnd_txn(1), pat != 1, pat != 0);
    end

    repeat (3) @(negedge i_Clock);
    chk("queues_drained", 32'(busq.size() + doneq.size() + slq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Two-port Wishbone arbiter that shares the single EFB Wishbone slave port (timer registers, e.g. TCCNT1 at 8'h66) between two internal requesters. Typical use: requester 0 is the LED colour poller and requester 1 is the UART-driven register access path. The block replaces the ad-hoc single-master strobe logic in the top level. It owns cyc/stb sequencing, round-robin fairness, an enforced idle gap between bus cycles, and an ack timeout so a stalled EFB cannot hang either requester.

## Interface
Parameters:
- TIMEOUT, 64, maximum cycles stb is held waiting for ack; legal range 1–255 (8-bit counter).

Ports:
- i_Clock  in  1  system clock (PLL output); all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req0 / i_Req1  in  1  transaction request; held high until the matching done pulse.
- i_We0 / i_We1  in  1  1 = write, 0 = read; valid while the matching req is high.
- i_Addr0 / i_Addr1  in  8  EFB register address.
- i_WData0 / i_WData1  in  8  write data.
- o_Done0 / o_Done1  out  1  one-cycle completion pulse to the granted requester.
- o_RData  out  8  read data; valid during done pulse, held until next completed read.
- o_Error  out  1  1 during a done pulse that ended by timeout; 0 otherwise.
- o_Busy  out  1  high in ACCESS and GAP.
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle/strobe to the EFB.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_adr  out  8  Wishbone address.
- o_wb_dat  out  8  Wishbone write data.
- i_wb_dat  in  8  Wishbone read data.
- i_wb_ack  in  1  Wishbone acknowledge.

## Operation
- All outputs registered. Reset values: every output 0. Internal last-grant = 1, so requester 0 wins the first tie.
- States: IDLE, ACCESS, GAP.
- IDLE: requests are sampled only here.
  - If exactly one req is high, grant it. If both are high, grant the requester not granted last.
  - Latch that requester's we/addr/wdata into o_wb_we/o_wb_adr/o_wb_dat.
  - Set cyc = stb = 1, clear the timeout counter, update last-grant, go to ACCESS.
- ACCESS: cyc/stb/we/adr/dat held stable.
  - On i_wb_ack: clear cyc/stb. For reads only, o_RData <= i_wb_dat (writes leave o_RData unchanged). Pulse the granted o_DoneN, set o_Error = 0, go to GAP.
  - Else if counter == TIMEOUT-1: clear cyc/stb, o_RData <= 8'h00, pulse o_DoneN with o_Error = 1, go to GAP.
  - Else increment the counter.
  - Ack on the same cycle the timeout would fire: the ack wins, o_Error = 0.
- GAP: one cycle with cyc = stb = 0 (EFB requires cyc low between cycles), then IDLE. o_Done*/o_Error return to 0.
- i_wb_ack in IDLE or GAP is ignored: no state change, no done pulse, o_RData unchanged.
- Requester protocol: drop req the cycle after its done pulse. Req still high when IDLE is re-entered is treated as a new transaction. A req that drops while not granted is simply not served.
- Address/we/wdata changes on a non-granted port have no effect. Changes on the granted port during ACCESS are ignored (latched copy used).
- Reset mid-transaction: at the next edge cyc/stb drop, state = IDLE, no done pulse, o_RData = 0.

## Timing
- Edge E0 samples req in IDLE. cyc/stb/adr are valid from E0 until the ack edge.
- Ack high before edge E1 (earliest E0+1): after E1, o_DoneN = 1 and cyc/stb = 0 for one cycle (GAP). IDLE after E1+1. Earliest next grant is at edge E1+2.
- Latency from req to done = 1 + ack latency cycles. Back-to-back throughput = one transaction per (3 + ack wait) cycles.
- Timeout: stb high exactly TIMEOUT cycles, then the done/error pulse.
- Both reqs held continuously: grants alternate 0,1,0,1…; neither requester waits more than one transaction.

## Test plan
- Single read: i_Req0 = 1, i_Addr0 = 8'h66; slave acks 2 cycles after stb with i_wb_dat = 8'hA5 -> o_wb_adr = 8'h66, o_wb_we = 0, o_Done0 pulses one cycle with o_RData = 8'hA5, o_Error = 0, cyc low for ≥1 cycle afterward.
- Write: i_Req1 = 1, i_We1 = 1, i_Addr1 = 8'h5E, i_WData1 = 8'h3C -> o_wb_we = 1, o_wb_dat = 8'h3C. After ack, o_Done1 pulses and o_RData keeps its previous value.
- Contention: both reqs held high for 6 transactions from reset -> grant order 0,1,0,1,0,1. No overlap of cyc; one GAP cycle between every pair.
- Timeout: TIMEOUT = 4, never ack -> stb high exactly 4 cycles, then o_Done0 = 1, o_Error = 1, o_RData = 8'h00. Ack arriving on the 4th cycle -> o_Error = 0 instead.
- Reset mid-ACCESS: assert i_Reset while stb is high -> all outputs 0 after the next edge, no done pulse. The next req is granted to requester 0 on a tie.
- Spurious ack: pulse i_wb_ack during IDLE and during GAP -> no done pulse, o_RData unchanged, state unaffected.
